credential_checker: RTL

//  Sits directly upstream of the access controller and produces its idChecked/passChecked inputs.

---
 rtl/access_pkg.sv | 8 +
 rtl/lockout_timer.sv | 24 ++
 rtl/credential_checker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/access_pkg.sv
// access_pkg: shared widths, default credential table and checker state encoding
package access_pkg;
  localparam int DIGIT_W = 4;
  localparam int CODE_W = 4 * DIGIT_W;
  localparam logic [CODE_W-1:0] DEF_ID = 16'h1234;
  localparam logic [CODE_W-1:0] DEF_PWD = 16'h0000;
  typedef enum logic [2:0] {IDLE, ID_SEARCH, ID_OK, GRANTED, LOCKED} state_t;
endpackage

// File: rtl/lockout_timer.sv
// lockout_timer: after a start pulse, raises done in the LOCK_CYCLES-th cycle and then stops
module lockout_timer #(
  parameter int LOCK_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);
  localparam int W = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
  logic [W-1:0] cnt;
  logic active;
  assign done = active && cnt == W'(LOCK_CYCLES - 1);
  // count from zero after start until the final cycle, then go idle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      active <= 1'b1;
    end else if (done) active <= 1'b0;
    else if (active) cnt <= cnt + 1'b1;
endmodule

// File: rtl/credential_checker.sv
// credential_checker: sequential ID table search and password check; LOCKOUT_EN adds failed-attempt lockout
module credential_checker
  import access_pkg::*;
#(
  parameter int NUM_USERS = 4,
  parameter logic [CODE_W*NUM_USERS-1:0] USER_IDS = {NUM_USERS{DEF_ID}},
  parameter logic [CODE_W*NUM_USERS-1:0] USER_PWDS = {NUM_USERS{DEF_PWD}},
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idStrobe,
  input  logic [CODE_W-1:0] idDigits,
  input  logic              pwdStrobe,
  input  logic [CODE_W-1:0] pwdDigits,
  input  logic              clearReq,
  output logic              idChecked,
  output logic              passChecked,
  output logic              idReject,
  output logic              busy,
  output logic [3:0]        userIndex,
  output logic [3:0]        failCount,
  output logic              lockedOut
);
  state_t state, nxt;
  logic [3:0] idx, idx_n, uidx, uidx_n, fail, fail_n, fail_inc;
  logic [CODE_W-1:0] id_q, id_n, pwd_q, pwd_n;
  logic pend, pend_n, rej, rej_n, id_hit, pwd_hit;
  assign id_hit = id_q == USER_IDS[32'(idx)*CODE_W +: CODE_W];
  assign pwd_hit = pwd_q == USER_PWDS[32'(uidx)*CODE_W +: CODE_W];
  assign fail_inc = fail == 4'hF ? fail : fail + 1'b1;
  assign idChecked = state == ID_OK || state == GRANTED;
  assign passChecked = state == GRANTED;
  assign busy = state == ID_SEARCH;
  assign idReject = rej;
  assign userIndex = idChecked ? uidx : '0;
  assign failCount = fail;
`ifdef LOCKOUT_EN
  logic lock_start, lock_done;
  assign lockedOut = state == LOCKED;
  lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .start(lock_start), .done(lock_done)
  );
`else
  assign lockedOut = 1'b0;
`endif
  // next state: clearReq beats idStrobe beats pwdStrobe; a password is latched, then compared one edge later
  always_comb begin
    nxt = state;
    idx_n = idx;
    uidx_n = uidx;
    fail_n = fail;
    id_n = id_q;
    pwd_n = pwd_q;
    pend_n = 1'b0;
    rej_n = 1'b0;
`ifdef LOCKOUT_EN
    lock_start = 1'b0;
`endif
    case (state)
      IDLE:
        if (!clearReq && idStrobe) begin
          id_n = idDigits;
          idx_n = '0;
          nxt = ID_SEARCH;
        end
      ID_SEARCH:
        if (clearReq) nxt = IDLE;
        else if (id_hit) begin
          uidx_n = idx;
          nxt = ID_OK;
        end else if (32'(idx) == NUM_USERS - 1) begin
          rej_n = 1'b1;
          nxt = IDLE;
        end else idx_n = idx + 1'b1;
      ID_OK:
        if (clearReq) nxt = IDLE;
        else if (idStrobe) begin
          id_n = idDigits;
          idx_n = '0;
          nxt = ID_SEARCH;
        end else begin
          if (pend) begin
            if (pwd_hit) begin
              fail_n = '0;
              nxt = GRANTED;
            end else begin
              fail_n = fail_inc;
`ifdef LOCKOUT_EN
              if (32'(fail_inc) == MAX_ATTEMPTS) begin
                lock_start = 1'b1;
                nxt = LOCKED;
              end
`endif
            end
          end
          if (pwdStrobe && nxt == ID_OK) begin
            pwd_n = pwdDigits;
            pend_n = 1'b1;
          end
        end
      GRANTED: nxt = clearReq ? IDLE : GRANTED;
`ifdef LOCKOUT_EN
      LOCKED:
        if (lock_done) begin
          fail_n = '0;
          nxt = IDLE;
        end
`endif
      default: nxt = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      uidx <= '0;
      fail <= '0;
      id_q <= '0;
      pwd_q <= '0;
      pend <= 1'b0;
      rej <= 1'b0;
    end else begin
      state <= nxt;
      idx <= idx_n;
      uidx <= uidx_n;
      fail <= fail_n;
      id_q <= id_n;
      pwd_q <= pwd_n;
      pend <= pend_n;
      rej <= rej_n;
    end
endmodule
